// File: rtl/parity_frame_collector.sv
// Serial frame collector: start, 4 data bits (LSB first), parity, stop; latches nibble and a saturating error count.
// Optional SEL_DEBOUNCE_EN: synchronise and debounce btn_sel before the sel toggle.
module parity_frame_collector #(
  parameter bit ODD_PARITY      = 1'b0,
  parameter int TIMEOUT_CYCLES  = 255,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       bit_in,
  input  logic       bit_valid,
  input  logic       btn_sel,
  output logic [3:0] data_nibble,
  output logic [3:0] err_count,
  output logic       parity_err,
  output logic       frame_done,
  output logic       busy,
  output logic       sel
);

  // Handshake: bit_in is consumed only in a cycle with bit_valid=1; there is no backpressure.
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DATA   = 2'd1;
  localparam logic [1:0] S_PARITY = 2'd2;
  localparam logic [1:0] S_STOP   = 2'd3;

  localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  logic [1:0]    state;
  logic [3:0]    shreg;
  logic [1:0]    cnt;
  logic          par_bit;
  logic [TW-1:0] tcnt;
  logic          timeout_hit;
  logic          frame_good;
  logic [3:0]    err_next;

  assign busy        = (state != S_IDLE);
  assign timeout_hit = (TIMEOUT_CYCLES > 0) && busy && (tcnt == TW'(TIMEOUT_CYCLES));
  assign frame_good  = bit_in && ((^shreg ^ par_bit) == ODD_PARITY);
  assign err_next    = (err_count == 4'hF) ? 4'hF : err_count + 4'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      shreg       <= 4'd0;
      cnt         <= 2'd0;
      par_bit     <= 1'b0;
      tcnt        <= '0;
      data_nibble <= 4'd0;
      err_count   <= 4'd0;
      parity_err  <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (timeout_hit) begin
        // A strobe arriving in the timeout cycle is dropped along with the frame.
        state      <= S_IDLE;
        tcnt       <= '0;
        frame_done <= 1'b1;
        parity_err <= 1'b1;
        err_count  <= err_next;
      end else begin
        if (busy && !bit_valid) tcnt <= tcnt + TW'(1);
        else                    tcnt <= '0;
        case (state)
          S_IDLE: begin
            if (bit_valid && !bit_in) begin
              state <= S_DATA;
              cnt   <= 2'd0;
            end
          end
          S_DATA: begin
            if (bit_valid) begin
              shreg[cnt] <= bit_in;
              cnt        <= cnt + 2'd1;
              if (cnt == 2'd3) state <= S_PARITY;
            end
          end
          S_PARITY: begin
            if (bit_valid) begin
              par_bit <= bit_in;
              state   <= S_STOP;
            end
          end
          default: begin
            if (bit_valid) begin
              state      <= S_IDLE;
              frame_done <= 1'b1;
              if (frame_good) begin
                data_nibble <= shreg;
                parity_err  <= 1'b0;
              end else begin
                parity_err <= 1'b1;
                err_count  <= err_next;
              end
            end
          end
        endcase
      end
    end
  end

  logic btn_rise;

`ifdef SEL_DEBOUNCE_EN
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          btn_s1;
  logic          btn_s2;
  logic [DW-1:0] deb_cnt;
  logic          deb_level;
  logic          deb_prev;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      btn_s1    <= 1'b0;
      btn_s2    <= 1'b0;
      deb_cnt   <= '0;
      deb_level <= 1'b0;
      deb_prev  <= 1'b0;
    end else begin
      btn_s1   <= btn_sel;
      btn_s2   <= btn_s1;
      deb_prev <= deb_level;
      // The level flips only after DEBOUNCE_CYCLES consecutive samples that disagree with it.
      if (btn_s2 == deb_level) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
        deb_level <= btn_s2;
        deb_cnt   <= '0;
      end else begin
        deb_cnt <= deb_cnt + DW'(1);
      end
    end
  end

  assign btn_rise = deb_level & ~deb_prev;
`else
  logic btn_r;
  logic btn_r_d;
  logic unused_debounce_cfg;

  assign unused_debounce_cfg = ^DEBOUNCE_CYCLES;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      btn_r   <= 1'b0;
      btn_r_d <= 1'b0;
    end else begin
      btn_r   <= btn_sel;
      btn_r_d <= btn_r;
    end
  end

  assign btn_rise = btn_r & ~btn_r_d;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n)        sel <= 1'b0;
    else if (btn_rise) sel <= ~sel;
  end

endmodule
